// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that locks the output channel to one requester for a whole
// burst and forwards accepted beats through a single registered output stage.
module rr_burst_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            s_valid_i,
  output logic [NUM_REQ-1:0]            s_ready_o,
  input  logic [NUM_REQ-1:0]            s_last_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [ADDR_WIDTH-1:0]         m_addr_o,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic [ID_WIDTH-1:0]           m_id_o,
  output logic                          m_last_o,
  output logic                          busy_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     gnt_id_q, gnt_id_d;
  logic                    m_valid_q, m_valid_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [ID_WIDTH-1:0]     m_id_q, m_id_d;
  logic                    m_last_q, m_last_d;

  logic                    out_free_c;
  logic                    cand_found_c;
  logic [ID_WIDTH-1:0]     cand_c;
  logic [ID_WIDTH-1:0]     sel_c;
  logic [ADDR_WIDTH-1:0]   sel_addr_c;
  logic [DATA_WIDTH-1:0]   sel_data_c;
  logic                    sel_last_c;
  logic [NUM_REQ-1:0]      ready_c;
  logic                    hs_c;

  assign out_free_c = !m_valid_q || m_ready_i;

  // Circular search starting just after rr_ptr: first the indices above it, then wrap to 0.
  always_comb begin
    cand_found_c = 1'b0;
    cand_c       = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!cand_found_c && s_valid_i[k] && (k > int'(rr_ptr_q))) begin
        cand_found_c = 1'b1;
        cand_c       = ID_WIDTH'(k);
      end
    end
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!cand_found_c && s_valid_i[k] && (k <= int'(rr_ptr_q))) begin
        cand_found_c = 1'b1;
        cand_c       = ID_WIDTH'(k);
      end
    end
  end

  // Payload mux for whichever requester currently owns (or is being offered) the channel.
  always_comb begin
    sel_c      = (state_q == ST_LOCKED) ? gnt_id_q : cand_c;
    sel_addr_c = '0;
    sel_data_c = '0;
    sel_last_c = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (ID_WIDTH'(k) == sel_c) begin
        sel_addr_c = s_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_c = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_last_c = s_last_i[k];
      end
    end
  end

  // Next-state, grant and output-register load logic.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_id_d  = gnt_id_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    m_last_d  = m_last_q;
    ready_c   = '0;

    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (rst_n && out_free_c && (ID_WIDTH'(k) == sel_c)) begin
        ready_c[k] = (state_q == ST_LOCKED) || cand_found_c;
      end
    end
    hs_c = |(s_valid_i & ready_c);

    case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          if (sel_last_c) begin
            rr_ptr_d = cand_c;
          end else begin
            state_d  = ST_LOCKED;
            gnt_id_d = cand_c;
          end
        end
      end
      ST_LOCKED: begin
        if (hs_c && sel_last_c) begin
          state_d  = ST_IDLE;
          rr_ptr_d = gnt_id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hs_c) begin
      m_valid_d = 1'b1;
      m_addr_d  = sel_addr_c;
      m_data_d  = sel_data_c;
      m_id_d    = sel_c;
      m_last_d  = sel_last_c;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= ID_WIDTH'(NUM_REQ - 1);
      gnt_id_q  <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_id_q  <= gnt_id_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s_ready_o = ready_c;
  assign m_valid_o = m_valid_q;
  assign m_addr_o  = m_addr_q;
  assign m_data_o  = m_data_q;
  assign m_id_o    = m_id_q;
  assign m_last_o  = m_last_q;
  assign busy_o    = (state_q == ST_LOCKED);

endmodule
